// File: rtl/bcp_pkg.sv
// Shared BCP accelerator types: implication entry layout {var, value} and helpers.
package bcp_pkg;

  localparam int unsigned FORMULA_MAX_VARIABLE    = 20;
  localparam int unsigned VARIABLE_ENCODING_LEN   = $clog2(FORMULA_MAX_VARIABLE + 1);
  localparam int unsigned VARIABLE_ASSIGNMENT_LEN = 1;
  localparam int unsigned WIDTH                   = VARIABLE_ENCODING_LEN + VARIABLE_ASSIGNMENT_LEN;

  typedef struct packed {
    logic [VARIABLE_ENCODING_LEN-1:0]   var_id;
    logic [VARIABLE_ASSIGNMENT_LEN-1:0] val;
  } implication_t;

  // Variable index 0 is reserved as "no implication".
  function automatic logic is_null(input implication_t imp);
    return imp.var_id == '0;
  endfunction

endpackage

// File: rtl/impl_lane_compactor.sv
// Prefix-sum over live write lanes (valid and non-null): per-lane slot offset
// relative to the write pointer, plus the total number of entries written.
module impl_lane_compactor
  import bcp_pkg::*;
#(
  parameter int unsigned NUM_WR_PORTS          = 4,
  parameter int unsigned VARIABLE_ENCODING_LEN = bcp_pkg::VARIABLE_ENCODING_LEN,
  parameter int unsigned OFF_LEN               = $clog2(NUM_WR_PORTS + 1)
) (
  input  logic [NUM_WR_PORTS-1:0]                       wr_valid_i,
  input  logic [NUM_WR_PORTS*VARIABLE_ENCODING_LEN-1:0] lane_var_i,
  output logic [NUM_WR_PORTS-1:0]                       live_o,
  output logic [NUM_WR_PORTS*OFF_LEN-1:0]               offset_o,
  output logic [OFF_LEN-1:0]                            nwr_o
);

  logic [OFF_LEN-1:0] acc;

  always_comb begin
    live_o   = '0;
    offset_o = '0;
    acc      = '0;
    for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
      live_o[k] = wr_valid_i[k] &&
                  (lane_var_i[k*VARIABLE_ENCODING_LEN +: VARIABLE_ENCODING_LEN] != '0);
      offset_o[k*OFF_LEN +: OFF_LEN] = acc;
      acc = acc + OFF_LEN'(live_o[k]);
    end
    nwr_o = acc;
  end

endmodule

// File: rtl/implication_fifo_mw.sv
// Multi-write-port show-ahead implication FIFO with all-or-nothing write acceptance.
// Optional IMPL_CONFLICT_DETECT_EN adds a sticky same-cycle lane conflict flag.
module implication_fifo_mw
  import bcp_pkg::*;
#(
  parameter int unsigned FORMULA_MAX_VARIABLE    = bcp_pkg::FORMULA_MAX_VARIABLE,
  parameter int unsigned VARIABLE_ENCODING_LEN   = $clog2(FORMULA_MAX_VARIABLE + 1),
  parameter int unsigned VARIABLE_ASSIGNMENT_LEN = bcp_pkg::VARIABLE_ASSIGNMENT_LEN,
  parameter int unsigned WIDTH                   = VARIABLE_ENCODING_LEN + VARIABLE_ASSIGNMENT_LEN,
  parameter int unsigned NUM_WR_PORTS            = 4,
  parameter int unsigned BUFFER_SIZE             = 16,
  parameter int unsigned COUNT_LEN               = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic [NUM_WR_PORTS-1:0]       wr_valid_i,
  input  logic [NUM_WR_PORTS*WIDTH-1:0] implication_i,
  output logic                          wr_ready_o,
  input  logic                          rd_i,
  output logic [WIDTH-1:0]              implication_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [COUNT_LEN-1:0]          count_o,
  output logic                          overflow_o
`ifdef IMPL_CONFLICT_DETECT_EN
 ,output logic                          conflict_o
`endif
);

  localparam int unsigned PTR_LEN = $clog2(BUFFER_SIZE);
  localparam int unsigned OFF_LEN = $clog2(NUM_WR_PORTS + 1);

  logic [WIDTH-1:0]     mem_q [BUFFER_SIZE];
  logic [PTR_LEN-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [COUNT_LEN-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic [NUM_WR_PORTS*VARIABLE_ENCODING_LEN-1:0] lane_var;
  logic [NUM_WR_PORTS-1:0]                       live;
  logic [NUM_WR_PORTS*OFF_LEN-1:0]               offset;
  logic [OFF_LEN-1:0]                            nwr;
  logic                                          wr_accept, wr_reject, pop;

  always_comb begin
    lane_var = '0;
    for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
      lane_var[k*VARIABLE_ENCODING_LEN +: VARIABLE_ENCODING_LEN] =
        implication_i[k*WIDTH+VARIABLE_ASSIGNMENT_LEN +: VARIABLE_ENCODING_LEN];
    end
  end

  impl_lane_compactor #(
    .NUM_WR_PORTS          (NUM_WR_PORTS),
    .VARIABLE_ENCODING_LEN (VARIABLE_ENCODING_LEN),
    .OFF_LEN               (OFF_LEN)
  ) u_compactor (
    .wr_valid_i (wr_valid_i),
    .lane_var_i (lane_var),
    .live_o     (live),
    .offset_o   (offset),
    .nwr_o      (nwr)
  );

  // Readiness depends only on registered occupancy so a same-cycle pop never frees room.
  assign wr_ready_o = (COUNT_LEN'(BUFFER_SIZE) - count_q) >= COUNT_LEN'(NUM_WR_PORTS);
  assign wr_accept  = wr_ready_o && (|live);
  assign wr_reject  = !wr_ready_o && (|live);
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == COUNT_LEN'(BUFFER_SIZE));
  assign pop        = rd_i && !empty_o;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign implication_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_i && en_i && !flush_i && wr_accept) begin
      for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
        if (live[k]) begin
          mem_q[wr_ptr_q + PTR_LEN'(offset[k*OFF_LEN +: OFF_LEN])] <= implication_i[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_LEN'(nwr);
      if (wr_reject) overflow_d = 1'b1;
      if (pop)       rd_ptr_d = rd_ptr_q + PTR_LEN'(1);
      count_d = count_q + (wr_accept ? COUNT_LEN'(nwr) : '0) - COUNT_LEN'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (en_i) begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef IMPL_CONFLICT_DETECT_EN
  logic conflict_q, conflict_d, lane_clash;

  always_comb begin
    lane_clash = 1'b0;
    for (int unsigned i = 0; i < NUM_WR_PORTS; i++) begin
      for (int unsigned j = i + 1; j < NUM_WR_PORTS; j++) begin
        if (live[i] && live[j] &&
            implication_i[i*WIDTH+VARIABLE_ASSIGNMENT_LEN +: VARIABLE_ENCODING_LEN] ==
            implication_i[j*WIDTH+VARIABLE_ASSIGNMENT_LEN +: VARIABLE_ENCODING_LEN] &&
            implication_i[i*WIDTH +: VARIABLE_ASSIGNMENT_LEN] !=
            implication_i[j*WIDTH +: VARIABLE_ASSIGNMENT_LEN]) begin
          lane_clash = 1'b1;
        end
      end
    end
  end

  assign conflict_d = flush_i ? 1'b0 : (conflict_q | (wr_accept & lane_clash));
  assign conflict_o = conflict_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     conflict_q <= 1'b0;
    else if (en_i) conflict_q <= conflict_d;
  end
`endif

endmodule

// File: tb/tb_implication_fifo_mw.sv
// Randomized scoreboard bench for implication_fifo_mw; conflict_o is checked
// only when IMPL_CONFLICT_DETECT_EN is defined.
module tb_implication_fifo_mw;
  import bcp_pkg::*;

  localparam int NWR = 4;
  localparam int BUF = 16;
  localparam int W   = bcp_pkg::WIDTH;

  logic           clk = 1'b0;
  logic           rst, en, flush, rd;
  logic [NWR-1:0] wr_valid;
  logic [NWR*W-1:0] lanes;
  logic           wr_ready, empty, full, overflow;
  logic [W-1:0]   head;
  logic [4:0]     count;
`ifdef IMPL_CONFLICT_DETECT_EN
  logic           conflict;
`endif

  always #5 clk = ~clk;

  implication_fifo_mw #(
    .NUM_WR_PORTS (NWR),
    .BUFFER_SIZE  (BUF)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .flush_i       (flush),
    .wr_valid_i    (wr_valid),
    .implication_i (lanes),
    .wr_ready_o    (wr_ready),
    .rd_i          (rd),
    .implication_o (head),
    .empty_o       (empty),
    .full_o        (full),
    .count_o       (count),
    .overflow_o    (overflow)
`ifdef IMPL_CONFLICT_DETECT_EN
   ,.conflict_o    (conflict)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of stored entries plus sticky flags.
  logic [W-1:0] exp_q[$];
  int   mdl_cnt   = 0;
  bit   mdl_ovf   = 0;
  bit   mdl_conf  = 0;
  bit   mdl_valid = 0;
  int   m_live;
  implication_t ei, ej;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_cnt = 0; mdl_ovf = 0; mdl_conf = 0; mdl_valid = 1;
    end else if (en && mdl_valid) begin
      if (flush) begin
        exp_q.delete();
        mdl_cnt = 0; mdl_ovf = 0; mdl_conf = 0;
      end else begin
        m_live = 0;
        for (int k = 0; k < NWR; k++) begin
          ei = implication_t'(lanes[k*W +: W]);
          if (wr_valid[k] && !is_null(ei)) m_live++;
        end
        if (m_live > 0 && (BUF - mdl_cnt) >= NWR) begin
          for (int k = 0; k < NWR; k++) begin
            ei = implication_t'(lanes[k*W +: W]);
            if (wr_valid[k] && !is_null(ei)) exp_q.push_back(lanes[k*W +: W]);
            for (int j = k + 1; j < NWR; j++) begin
              ej = implication_t'(lanes[j*W +: W]);
              if (wr_valid[k] && wr_valid[j] && !is_null(ei) && !is_null(ej) &&
                  ei.var_id == ej.var_id && ei.val != ej.val) mdl_conf = 1;
            end
          end
        end else if (m_live > 0) begin
          mdl_ovf = 1;
        end
        mdl_cnt = mdl_cnt + ((BUF - mdl_cnt) >= NWR ? m_live : 0) - ((rd && mdl_cnt > 0) ? 1 : 0);
      end
    end
  end

  // Monitor: status every cycle; head compared and retired whenever a pop will happen.
  always @(negedge clk) begin
    if (mdl_valid && !rst) begin
      check("count", 32'(count), 32'(mdl_cnt));
      check("empty", 32'(empty), 32'(mdl_cnt == 0));
      check("full", 32'(full), 32'(mdl_cnt == BUF));
      check("wr_ready", 32'(wr_ready), 32'((BUF - mdl_cnt) >= NWR));
      check("overflow", 32'(overflow), 32'(mdl_ovf));
`ifdef IMPL_CONFLICT_DETECT_EN
      check("conflict", 32'(conflict), 32'(mdl_conf));
`endif
      if (mdl_cnt > 0) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard_empty: got head %0h expected none queued", head);
        end else begin
          check("head", 32'(head), 32'(exp_q[0]));
          if (rd && en && !flush) void'(exp_q.pop_front());
        end
      end else begin
        check("head_when_empty", 32'(head), 32'(0));
      end
    end
  end

  function automatic logic [W-1:0] mk(input int v, input int b);
    logic [4:0] vv;
    logic       bb;
    vv = 5'(v);
    bb = 1'(b);
    return {vv, bb};
  endfunction

  task automatic step(input logic r, input logic e, input logic f,
                      input logic [NWR-1:0] v, input logic [NWR*W-1:0] l, input logic rdv);
    rst = r; en = e; flush = f; wr_valid = v; lanes = l; rd = rdv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, '0, '0, 0);
  endtask

  function automatic logic [NWR*W-1:0] rand_lanes(input bit nonnull);
    logic [NWR*W-1:0] l;
    for (int k = 0; k < NWR; k++)
      l[k*W +: W] = mk(nonnull ? int'($urandom_range(1, 20)) : int'($urandom_range(0, 20)),
                       int'($urandom_range(0, 1)));
    return l;
  endfunction

  initial begin
    rst = 1; en = 1; flush = 0; rd = 0; wr_valid = '0; lanes = '0;
    step(1, 1, 0, '0, '0, 0);
    step(1, 1, 0, '0, '0, 0);
    idle(1);

    // Lane packing with a null lane in the middle.
    step(0, 1, 0, 4'hF, {mk(7, 1), mk(0, 1), mk(5, 0), mk(3, 1)}, 0);
    idle(1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, '0, 1);

    // Fill to 13, then an over-capacity write is dropped; flush clears.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'hF, rand_lanes(1), 0);
    step(0, 1, 0, 4'h1, rand_lanes(1), 0);
    step(0, 1, 0, 4'hF, rand_lanes(1), 0);
    idle(2);
    step(0, 1, 1, '0, '0, 0);
    idle(1);

    // Streaming one-in/one-out across pointer wrap.
    step(0, 1, 0, 4'h3, rand_lanes(1), 0);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 4'h1, rand_lanes(1), 1);
    idle(1);

    // Write and read together on an empty FIFO: nothing popped.
    step(0, 1, 1, '0, '0, 0);
    step(0, 1, 0, 4'h1, {18'h0, mk(9, 1)}, 1);
    idle(1);

    // Disabled cycle freezes everything.
    step(0, 0, 0, 4'hF, rand_lanes(1), 1);
    idle(1);

    // Same-variable opposite values in one accepted cycle.
    step(0, 1, 1, '0, '0, 0);
    step(0, 1, 0, 4'h3, {12'h0, mk(4, 0), mk(4, 1)}, 0);
    idle(2);
    step(0, 1, 0, 4'h1, {18'h0, mk(6, 0)}, 1);

    // Randomized traffic: write-heavy then read-heavy phases.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 39) == 0),
             4'($urandom_range(0, 15)),
             rand_lanes(0),
             (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end
    end
    for (int i = 0; i < 20; i++) step(0, 1, 0, '0, '0, 1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
